rot_row_collector: RTL and testbench
====================================

Name: rot_row_collector

Overview:
- Downstream companion of the RowRotation stage.
- Tracks which RowRotation input cycles carried valid rows, using a valid/tag delay line matched to the rotator's 2-cycle latency.
- Captures each rotated row (H row plus y element) into a ping-pong frame buffer of NROW rows.
- Presents complete frames to the next QR stage with a valid/ready handshake, and back-pressures the row source with credits, because RowRotation itself cannot stall.

Parameters:
- N, 8, complex elements per H row; must match RowRotation N.
- NROW, 4, rows per frame (matrix height).
- LAT, 2, RowRotation register latency in cycles (BP0/BP1 flops); delay-line depth.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  row presented to RowRotation input this cycle.
- in_ready  out  1  collector can absorb one more row.
- hrot_x  in  WL*N  RowRotation Hout_x.
- hrot_y  in  WL*N  RowRotation Hout_y.
- yrot_x  in  WL  RowRotation Yout_x.
- yrot_y  in  WL  RowRotation Yout_y.
- frame_valid  out  1  full frame available.
- frame_ready  in  1  consumer accepts frame.
- frame_hx  out  WL*N*NROW  row r at bits [WL*N*r +: WL*N].
- frame_hy  out  WL*N*NROW  same packing as frame_hx.
- frame_yx  out  WL*NROW  row r at bits [WL*r +: WL].
- frame_yy  out  WL*NROW  same packing as frame_yx.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Accept: an accept occurs when in_valid && in_ready. The accept pushes a 1 into a LAT-deep valid shift register; a non-accept cycle pushes 0.
- Write: when the delay-line tail is 1, the row on hrot/yrot (the value that cycle) is written at row index wr of bank wb. wr then increments.
- Bank fill: when wr == NROW-1 is written, bank wb becomes FULL, wb toggles and wr wraps to 0.
- Bank states: each bank is EMPTY or FULL. A bank being filled is EMPTY until its last row lands.
- Read: rb selects the output bank. frame_valid = (bank[rb] == FULL). frame_* is driven combinationally from bank rb.
  - While frame_valid && !frame_ready, frame_* must stay stable.
- Release: on frame_valid && frame_ready, bank[rb] becomes EMPTY and rb toggles.
  - A write completing the other bank in the same cycle is legal; both updates apply.
- Credits:
  - Counter width clog2(2*NROW+1), reset value 2*NROW.
  - Accept: -1. Frame release: +NROW. Both in the same cycle: +NROW-1.
  - in_ready = (credits != 0). in_ready is a registered-state decode only; no combinational path from in_valid or frame_ready.
- Guarantees:
  - No row is ever lost.
  - With frame_ready held high, sustained throughput is 1 row/cycle with in_ready never dropping.
- Latency: the last row of a frame is accepted at cycle t; frame_valid rises at t+LAT+1. That is, the row is written at edge t+LAT and is visible after the edge.
- Reset values:
  - in_ready = 1, frame_valid = 0.
  - Both banks EMPTY; wb = rb = 0; wr = 0; delay line all 0.
  - Bank contents cleared, so frame_* = 0.
- Reset mid-operation: in-flight tokens are dropped by clearing the delay line. The unreset RowRotation pipeline may still emit stale data; it is ignored because its tail valid is 0. Partially filled banks are discarded.
- Arithmetic: no data arithmetic; rows are stored bit-exact as signed WL-bit words.

Decomposition:
- WL comes from the shared parameters.v.
- Add to parameters.v: ROT_LAT = 2, derived from BP0/BP1, so that RowRotation and this collector cannot diverge.
- One natural sub-module: rot_frame_bank. It holds one NROW x row store with write-enable/row-index and a packed read port. It is instantiated twice, with the ping-pong control kept in the top.

Test Plan:
- Single frame: after reset, feed 4 rows back-to-back with hrot_x element0 = 0x0100, 0x0200, 0x0300, 0x0400 at the tail-aligned cycles. frame_valid rises 3 cycles after the last accept, and frame_hx row r element0 = 0x0100*(r+1).
- Backpressure: hold frame_ready = 0 and stream 9 rows. in_ready drops after exactly 8 accepts and both banks are FULL. Raise frame_ready for 1 cycle: in_ready rises the next cycle with credits = 4, and frame 0 data remains stable until that handshake.
- Sustained streaming: frame_ready = 1, 40 consecutive in_valid. Expect 10 frames, in_ready never deasserts, and per-frame row order is preserved.
- Gapped input: in_valid pattern 1,0,0,1,1,0,1. Only 4 rows are captured, with no capture on the gap cycles even though hrot carries nonzero garbage.
- Simultaneous events: the last row of bank 1 lands in the same cycle that bank 0 handshakes. Expect bank 0 EMPTY, bank 1 FULL, rb = 1, frame_valid high the next cycle, and credits updated as +4-1 when an accept coincides.
- Reset mid-frame: assert rst with 2 rows in flight and 3 rows stored. After reset frame_valid = 0, in_ready = 1, and credits = 8. A fresh 4-row frame then emits only the new rows.

Source files
------------

// File: rtl/rot_row_collector_pkg.sv
// Shared constants and types for the RowRotation output collector.
// ROT_LAT mirrors the RowRotation BP0/BP1 register depth so the two cannot diverge.
package rot_row_collector_pkg;

  localparam int WL      = 16;
  localparam int ROT_LAT = 2;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_t;

endpackage

// File: rtl/rot_frame_bank.sv
// One NROW-row frame store: indexed row write, whole frame read as packed vectors.
// Row r of each output occupies bits [width*r +: width].
module rot_frame_bank #(
  parameter int N    = 8,
  parameter int NROW = 4,
  parameter int WL   = 16,
  parameter int RW   = (NROW > 1) ? $clog2(NROW) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [RW-1:0]          row,
  input  logic [WL*N-1:0]        hx,
  input  logic [WL*N-1:0]        hy,
  input  logic [WL-1:0]          yx,
  input  logic [WL-1:0]          yy,
  output logic [WL*N*NROW-1:0]   frame_hx,
  output logic [WL*N*NROW-1:0]   frame_hy,
  output logic [WL*NROW-1:0]     frame_yx,
  output logic [WL*NROW-1:0]     frame_yy
);

  logic [NROW-1:0][WL*N-1:0] hx_q;
  logic [NROW-1:0][WL*N-1:0] hy_q;
  logic [NROW-1:0][WL-1:0]   yx_q;
  logic [NROW-1:0][WL-1:0]   yy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hx_q <= '0;
      hy_q <= '0;
      yx_q <= '0;
      yy_q <= '0;
    end else if (we) begin
      hx_q[row] <= hx;
      hy_q[row] <= hy;
      yx_q[row] <= yx;
      yy_q[row] <= yy;
    end
  end

  assign frame_hx = hx_q;
  assign frame_hy = hy_q;
  assign frame_yx = yx_q;
  assign frame_yy = yy_q;

endmodule

// File: rtl/rot_row_collector.sv
// Collects rotated rows from RowRotation into a ping-pong pair of frame banks and
// hands complete frames downstream; credits throttle the (non-stallable) row source.
module rot_row_collector
  import rot_row_collector_pkg::*;
#(
  parameter int N    = 8,
  parameter int NROW = 4,
  parameter int LAT  = ROT_LAT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WL*N-1:0]       hrot_x,
  input  logic [WL*N-1:0]       hrot_y,
  input  logic [WL-1:0]         yrot_x,
  input  logic [WL-1:0]         yrot_y,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic [WL*N*NROW-1:0]  frame_hx,
  output logic [WL*N*NROW-1:0]  frame_hy,
  output logic [WL*NROW-1:0]    frame_yx,
  output logic [WL*NROW-1:0]    frame_yy
);

  localparam int CW = $clog2(2*NROW+1);
  localparam int RW = (NROW > 1) ? $clog2(NROW) : 1;

  // Handshakes: a row transfers when in_valid && in_ready, a frame when
  // frame_valid && frame_ready; neither ready depends combinationally on its valid.
  logic [LAT-1:0]   vld_q, vld_d;
  logic             wb_q, wb_d;
  logic             rb_q, rb_d;
  logic [RW-1:0]    wr_q, wr_d;
  bank_state_t      bank_q [2];
  bank_state_t      bank_d [2];
  logic [CW-1:0]    credits_q, credits_d;

  logic accept, tail, take, row_done, we0, we1;

  logic [WL*N*NROW-1:0] b0_hx, b0_hy, b1_hx, b1_hy;
  logic [WL*NROW-1:0]   b0_yx, b0_yy, b1_yx, b1_yy;

  assign in_ready    = (credits_q != '0);
  assign accept      = in_valid && in_ready;
  assign tail        = vld_q[LAT-1];
  assign frame_valid = (bank_q[rb_q] == BANK_FULL);
  assign take        = frame_valid && frame_ready;
  assign row_done    = tail && (wr_q == RW'(NROW-1));
  assign we0         = tail && !wb_q;
  assign we1         = tail && wb_q;

  always_comb begin
    vld_d     = (vld_q << 1) | LAT'(accept);
    wb_d      = wb_q;
    rb_d      = rb_q;
    wr_d      = wr_q;
    bank_d    = bank_q;
    credits_d = credits_q - CW'(accept) + (take ? CW'(NROW) : CW'(0));
    if (take) begin
      bank_d[rb_q] = BANK_EMPTY;
      rb_d         = !rb_q;
    end
    // Completing the other bank in the same cycle as a release is independent.
    if (tail) begin
      if (row_done) begin
        bank_d[wb_q] = BANK_FULL;
        wb_d         = !wb_q;
        wr_d         = '0;
      end else begin
        wr_d = wr_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      wb_q      <= 1'b0;
      rb_q      <= 1'b0;
      wr_q      <= '0;
      bank_q[0] <= BANK_EMPTY;
      bank_q[1] <= BANK_EMPTY;
      credits_q <= CW'(2*NROW);
    end else begin
      vld_q     <= vld_d;
      wb_q      <= wb_d;
      rb_q      <= rb_d;
      wr_q      <= wr_d;
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      credits_q <= credits_d;
    end
  end

  rot_frame_bank #(.N(N), .NROW(NROW), .WL(WL), .RW(RW)) u_bank0 (
    .clk      (clk),
    .rst      (rst),
    .we       (we0),
    .row      (wr_q),
    .hx       (hrot_x),
    .hy       (hrot_y),
    .yx       (yrot_x),
    .yy       (yrot_y),
    .frame_hx (b0_hx),
    .frame_hy (b0_hy),
    .frame_yx (b0_yx),
    .frame_yy (b0_yy)
  );

  rot_frame_bank #(.N(N), .NROW(NROW), .WL(WL), .RW(RW)) u_bank1 (
    .clk      (clk),
    .rst      (rst),
    .we       (we1),
    .row      (wr_q),
    .hx       (hrot_x),
    .hy       (hrot_y),
    .yx       (yrot_x),
    .yy       (yrot_y),
    .frame_hx (b1_hx),
    .frame_hy (b1_hy),
    .frame_yx (b1_yx),
    .frame_yy (b1_yy)
  );

  assign frame_hx = rb_q ? b1_hx : b0_hx;
  assign frame_hy = rb_q ? b1_hy : b0_hy;
  assign frame_yx = rb_q ? b1_yx : b0_yx;
  assign frame_yy = rb_q ? b1_yy : b0_yy;

endmodule

// File: tb/tb_rot_row_collector.sv
// Bench for rot_row_collector: a cycle-level reference model of accepted rows,
// credits and frame completion feeds an expected-frame queue checked by a monitor.
module tb_rot_row_collector;

  localparam int N    = 8;
  localparam int NROW = 4;
  localparam int LAT  = 2;
  localparam int WL   = 16;
  localparam int HW   = WL*N;
  localparam int FW   = 2*HW*NROW + 2*WL*NROW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [HW-1:0]        hrot_x = '0;
  logic [HW-1:0]        hrot_y = '0;
  logic [WL-1:0]        yrot_x = '0;
  logic [WL-1:0]        yrot_y = '0;
  logic                 frame_valid;
  logic                 frame_ready = 1'b0;
  logic [HW*NROW-1:0]   frame_hx, frame_hy;
  logic [WL*NROW-1:0]   frame_yx, frame_yy;

  rot_row_collector #(.N(N), .NROW(NROW), .LAT(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .hrot_x      (hrot_x),
    .hrot_y      (hrot_y),
    .yrot_x      (yrot_x),
    .yrot_y      (yrot_y),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_hx    (frame_hx),
    .frame_hy    (frame_hy),
    .frame_yx    (frame_yx),
    .frame_yy    (frame_yy)
  );

  // ---------------- reference model state ----------------
  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int hs_count    = 0;

  logic [FW-1:0] exp_q[$];
  int            due_q[$];     // cycle in which each accepted row appears at the rotator output
  int            outstanding;  // rows accepted whose frame has not yet been handed off
  int            frames_done;
  int            frames_rel;
  int            cur_rows;
  logic [HW*NROW-1:0] cur_hx, cur_hy;
  logic [WL*NROW-1:0] cur_yx, cur_yy;
  bit            tag_mode = 1'b0;
  bit            chk_zero = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    due_q.delete();
    exp_q.delete();
    outstanding = 0;
    frames_done = 0;
    frames_rel  = 0;
    cur_rows    = 0;
    cur_hx = '0; cur_hy = '0; cur_yx = '0; cur_yy = '0;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input bit v, input bit fr, input bit r);
    bit            exp_ready, exp_fv;
    logic [HW-1:0] hx, hy;
    logic [WL-1:0] yx, yy;
    @(posedge clk);
    #1;
    cyc++;
    exp_ready = (outstanding < 2*NROW);
    exp_fv    = (frames_done > frames_rel);
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    check("frame_valid", 64'(frame_valid), 64'(exp_fv));
    if (chk_zero) begin
      chk_zero = 1'b0;
      check("reset_frame_zero", 64'(|{frame_hx, frame_hy, frame_yx, frame_yy}), 64'(0));
    end
    hx = {$urandom, $urandom, $urandom, $urandom};
    hy = {$urandom, $urandom, $urandom, $urandom};
    yx = WL'($urandom);
    yy = WL'($urandom);
    if (tag_mode && due_q.size() > 0 && due_q[0] == cyc)
      hx[WL-1:0] = WL'(32'h0100 * (cur_rows + 1));
    rst         = r;
    in_valid    = v;
    frame_ready = fr;
    hrot_x = hx; hrot_y = hy; yrot_x = yx; yrot_y = yy;
    if (r) begin
      model_reset();
    end else begin
      if (v && exp_ready) begin
        due_q.push_back(cyc + LAT);
        outstanding++;
      end
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        cur_hx[HW*cur_rows +: HW] = hx;
        cur_hy[HW*cur_rows +: HW] = hy;
        cur_yx[WL*cur_rows +: WL] = yx;
        cur_yy[WL*cur_rows +: WL] = yy;
        cur_rows++;
        if (cur_rows == NROW) begin
          exp_q.push_back({cur_hx, cur_hy, cur_yx, cur_yy});
          frames_done++;
          cur_rows = 0;
        end
      end
      if (exp_fv && fr) begin
        frames_rel++;
        outstanding -= NROW;
      end
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [FW-1:0] held;
  bit            held_v = 1'b0;

  task automatic cmp_frame(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    logic [63:0] a64, e64;
    int          bad;
    vectors++;
    if (act !== exp) begin
      miscompares++;
      bad = 0;
      for (int i = 0; i < FW/64; i++) begin
        if (act[64*i +: 64] !== exp[64*i +: 64]) begin
          bad = i;
          break;
        end
      end
      a64 = act[64*bad +: 64];
      e64 = exp[64*bad +: 64];
      $display("FAIL %s cycle %0d word %0d: got %h expected %h", name, cyc, bad, a64, e64);
    end
  endtask

  always @(negedge clk) begin
    logic [FW-1:0] act;
    act = {frame_hx, frame_hy, frame_yx, frame_yy};
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v && frame_valid) cmp_frame("frame_stable", act, held);
      if (frame_valid && frame_ready) begin
        hs_count++;
        held_v = 1'b0;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL frame_unexpected cycle %0d: got handshake expected none", cyc);
        end else begin
          cmp_frame("frame_data", act, exp_q.pop_front());
        end
      end else if (frame_valid) begin
        held   = act;
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  int hs_before;
  int gap_pat[7] = '{1, 0, 0, 1, 1, 0, 1};

  initial begin
    model_reset();
    repeat (3) step(0, 0, 1);
    chk_zero = 1'b1;

    // Single tagged frame, then release it.
    tag_mode = 1'b1;
    repeat (NROW) step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    check("single_elem0_row3", 64'(frame_hx[HW*3 +: WL]), 64'h0400);
    repeat (2) step(0, 1, 0);
    tag_mode = 1'b0;

    // Backpressure: both banks fill, then a single-cycle release.
    repeat (12) step(1, 0, 0);
    step(0, 1, 0);
    repeat (3) step(0, 0, 0);
    repeat (3) step(0, 1, 0);

    // Sustained streaming with the consumer always ready.
    hs_before = hs_count;
    repeat (40) step(1, 1, 0);
    repeat (6) step(0, 1, 0);
    check("sustained_frames", 64'(hs_count - hs_before), 64'(10));

    // Gapped input with garbage on the idle cycles.
    hs_before = hs_count;
    foreach (gap_pat[i]) step(gap_pat[i][0], 0, 0);
    repeat (4) step(0, 0, 0);
    repeat (3) step(0, 1, 0);
    check("gapped_frames", 64'(hs_count - hs_before), 64'(1));

    // Bank 1 completes in the cycle bank 0 is handed off.
    repeat (2*NROW) step(1, 0, 0);
    step(0, 0, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    repeat (3) step(0, 1, 0);

    // Random traffic on both sides.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 0);
    repeat (8) step(0, 1, 0);

    // Reset with 3 rows stored and 2 in flight, then a fresh frame.
    repeat (5) step(1, 0, 0);
    step(0, 0, 1);
    chk_zero = 1'b1;
    repeat (NROW) step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    repeat (3) step(0, 1, 0);

    // Bounded drain of anything still expected.
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) step(0, 1, 0);
    step(0, 0, 0);
    check("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
